// File: rtl/stopwatch_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl_if
// Brief    : Button/tick inputs and display/status outputs of stopwatch_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface stopwatch_ctrl_if;
  logic       tick;
  logic       start_pulse;
  logic       lap_pulse;
  logic       clear_pulse;
  logic       count_enable;
  logic [3:0] disp_min_t;
  logic [3:0] disp_min_o;
  logic [3:0] disp_sec_t;
  logic [3:0] disp_sec_o;
  logic       lap_active;
  logic       wrap_evt;
  logic [2:0] state;

  modport master (
    output tick, start_pulse, lap_pulse, clear_pulse,
    input  count_enable, disp_min_t, disp_min_o, disp_sec_t, disp_sec_o,
    input  lap_active, wrap_evt, state
  );

  modport slave (
    input  tick, start_pulse, lap_pulse, clear_pulse,
    output count_enable, disp_min_t, disp_min_o, disp_sec_t, disp_sec_o,
    output lap_active, wrap_evt, state
  );
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Brief    : Run/pause/lap/clear sequencer with mm:ss BCD counter and lap hold.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
  parameter int MIN_MAX = 59,
  parameter bit WRAP    = 1'b1
) (
  input  wire              clk,
  input  wire              reset,
  stopwatch_ctrl_if.slave  sw
);

  localparam logic [3:0] c_max_t = 4'(MIN_MAX / 10);
  localparam logic [3:0] c_max_o = 4'(MIN_MAX % 10);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    LAP   = 3'd3
  } state_t;

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
  } bcd_time_t;

  state_t    r_state, w_state_next;
  bcd_time_t r_cnt, r_lap, w_cnt_inc, w_cnt_next, w_lap_next;
  logic      r_wrap_evt;
  logic      w_running, w_inc, w_terminal, w_saturate, w_clear, w_capture;

  assign w_running  = (r_state == RUN) || (r_state == LAP);
  assign w_inc      = sw.tick & w_running;
  assign w_terminal = (r_cnt.min_t == c_max_t) && (r_cnt.min_o == c_max_o) &&
                      (r_cnt.sec_t == 4'd5)    && (r_cnt.sec_o == 4'd9);
  assign w_saturate = w_inc & w_terminal & (WRAP == 1'b0);

  // Ripple BCD increment; the terminal count is handled separately, so min_t never overflows.
  always_comb begin
    w_cnt_inc = r_cnt;
    if (r_cnt.sec_o != 4'd9) begin
      w_cnt_inc.sec_o = r_cnt.sec_o + 4'd1;
    end else begin
      w_cnt_inc.sec_o = 4'd0;
      if (r_cnt.sec_t != 4'd5) begin
        w_cnt_inc.sec_t = r_cnt.sec_t + 4'd1;
      end else begin
        w_cnt_inc.sec_t = 4'd0;
        if (r_cnt.min_o != 4'd9) begin
          w_cnt_inc.min_o = r_cnt.min_o + 4'd1;
        end else begin
          w_cnt_inc.min_o = 4'd0;
          w_cnt_inc.min_t = r_cnt.min_t + 4'd1;
        end
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (sw.start_pulse) w_state_next = RUN;
      end
      RUN: begin
        if (sw.start_pulse) begin
          w_state_next = PAUSE;
        end else if (sw.lap_pulse) begin
          w_state_next = LAP;
          w_capture    = 1'b1;
        end
      end
      LAP: begin
        if (sw.start_pulse)    w_state_next = PAUSE;
        else if (sw.lap_pulse) w_state_next = RUN;
      end
      PAUSE: begin
        if (sw.clear_pulse) begin
          w_state_next = IDLE;
          w_clear      = 1'b1;
        end else if (sw.start_pulse) begin
          w_state_next = RUN;
        end
      end
      default: w_state_next = IDLE;
    endcase
    // Saturation forces a pause and cancels any lap capture on the same edge.
    if (w_saturate) begin
      w_state_next = PAUSE;
      w_capture    = 1'b0;
    end
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_clear) begin
      w_cnt_next = '0;
    end else if (w_inc) begin
      if (!w_terminal)  w_cnt_next = w_cnt_inc;
      else if (WRAP)    w_cnt_next = '0;
    end
  end

  always_comb begin
    w_lap_next = r_lap;
    if (w_clear)        w_lap_next = '0;
    else if (w_capture) w_lap_next = r_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_lap      <= '0;
      r_wrap_evt <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_lap      <= w_lap_next;
      r_wrap_evt <= w_inc & w_terminal;
    end
  end

  assign sw.count_enable = w_running;
  assign sw.lap_active   = (r_state == LAP);
  assign sw.wrap_evt     = r_wrap_evt;
  assign sw.state        = r_state;
  assign sw.disp_min_t   = (r_state == LAP) ? r_lap.min_t : r_cnt.min_t;
  assign sw.disp_min_o   = (r_state == LAP) ? r_lap.min_o : r_cnt.min_o;
  assign sw.disp_sec_t   = (r_state == LAP) ? r_lap.sec_t : r_cnt.sec_t;
  assign sw.disp_sec_o   = (r_state == LAP) ? r_lap.sec_o : r_cnt.sec_o;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Brief    : Scoreboard bench; three configurations driven by shared stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

  localparam int NDUT = 3;
  localparam int OW   = 22;
  typedef logic [OW-1:0]      obs_t;
  typedef logic [NDUT*OW-1:0] exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic d_tick = 1'b0, d_start = 1'b0, d_lap = 1'b0, d_clear = 1'b0;
  always #5 clk = ~clk;

  stopwatch_ctrl_if if_a ();
  stopwatch_ctrl_if if_b ();
  stopwatch_ctrl_if if_c ();

  stopwatch_ctrl #(.MIN_MAX(59), .WRAP(1'b1)) dut_a (.clk(clk), .reset(reset), .sw(if_a.slave));
  stopwatch_ctrl #(.MIN_MAX(59), .WRAP(1'b0)) dut_b (.clk(clk), .reset(reset), .sw(if_b.slave));
  stopwatch_ctrl #(.MIN_MAX(1),  .WRAP(1'b0)) dut_c (.clk(clk), .reset(reset), .sw(if_c.slave));

  assign if_a.tick = d_tick;  assign if_a.start_pulse = d_start;
  assign if_a.lap_pulse = d_lap; assign if_a.clear_pulse = d_clear;
  assign if_b.tick = d_tick;  assign if_b.start_pulse = d_start;
  assign if_b.lap_pulse = d_lap; assign if_b.clear_pulse = d_clear;
  assign if_c.tick = d_tick;  assign if_c.start_pulse = d_start;
  assign if_c.lap_pulse = d_lap; assign if_c.clear_pulse = d_clear;

  obs_t obs [NDUT];
  assign obs[0] = {if_a.state, if_a.count_enable, if_a.lap_active, if_a.wrap_evt,
                   if_a.disp_min_t, if_a.disp_min_o, if_a.disp_sec_t, if_a.disp_sec_o};
  assign obs[1] = {if_b.state, if_b.count_enable, if_b.lap_active, if_b.wrap_evt,
                   if_b.disp_min_t, if_b.disp_min_o, if_b.disp_sec_t, if_b.disp_sec_o};
  assign obs[2] = {if_c.state, if_c.count_enable, if_c.lap_active, if_c.wrap_evt,
                   if_c.disp_min_t, if_c.disp_min_o, if_c.disp_sec_t, if_c.disp_sec_o};

  // Reference model: elapsed time as plain seconds, mode as 0=IDLE 1=RUN 2=PAUSE 3=LAP.
  int m_mode [NDUT];
  int m_secs [NDUT];
  int m_lap  [NDUT];
  bit m_wev  [NDUT];

  exp_t exp_q [$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_cyc = 0;

  function automatic int max_min_of(int i);
    return (i == 2) ? 1 : 59;
  endfunction

  function automatic bit wrap_of(int i);
    return (i == 0);
  endfunction

  function automatic obs_t expect_of(int i);
    int v, mm, ss;
    v  = (m_mode[i] == 3) ? m_lap[i] : m_secs[i];
    mm = v / 60;
    ss = v % 60;
    return {3'(m_mode[i]), (m_mode[i] == 1 || m_mode[i] == 3), (m_mode[i] == 3), m_wev[i],
            4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic model_step(input bit rs, input bit t, input bit s, input bit l, input bit c);
    for (int i = 0; i < NDUT; i++) begin
      if (rs) begin
        m_mode[i] = 0; m_secs[i] = 0; m_lap[i] = 0; m_wev[i] = 1'b0;
      end else begin
        int  top, nmode, nlap, nsecs;
        bit  inc, term;
        top   = max_min_of(i) * 60 + 59;
        inc   = t && (m_mode[i] == 1 || m_mode[i] == 3);
        term  = inc && (m_secs[i] == top);
        nmode = m_mode[i];
        nlap  = m_lap[i];
        nsecs = m_secs[i];
        if (inc) nsecs = term ? (wrap_of(i) ? 0 : m_secs[i]) : m_secs[i] + 1;
        case (m_mode[i])
          0: if (s) nmode = 1;
          1: if (s) nmode = 2; else if (l) begin nmode = 3; nlap = m_secs[i]; end
          3: if (s) nmode = 2; else if (l) nmode = 1;
          2: if (c) begin nmode = 0; nsecs = 0; nlap = 0; end else if (s) nmode = 1;
          default: nmode = 0;
        endcase
        if (term && !wrap_of(i)) begin
          nmode = 2;
          nlap  = m_lap[i];
        end
        m_mode[i] = nmode; m_secs[i] = nsecs; m_lap[i] = nlap; m_wev[i] = term;
      end
    end
  endtask

  task automatic cycle(input bit t, input bit s, input bit l, input bit c, input bit rs);
    exp_t e;
    @(negedge clk);
    d_tick = t; d_start = s; d_lap = l; d_clear = c; reset = rs;
    model_step(rs, t, s, l, c);
    for (int i = 0; i < NDUT; i++) e[i*OW +: OW] = expect_of(i);
    exp_q.push_back(e);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle the DUT outputs are a response; pop and compare.
  always @(posedge clk) begin
    #1;
    n_cyc++;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      for (int i = 0; i < NDUT; i++) begin
        obs_t want;
        want = e[i*OW +: OW];
        n_vec++;
        if (obs[i] !== want) begin
          n_err++;
          $display("FAIL dut%0d cyc%0d: got st=%0d ce=%b la=%b wev=%b %h:%h required st=%0d ce=%b la=%b wev=%b %h:%h",
                   i, n_cyc, obs[i][21:19], obs[i][18], obs[i][17], obs[i][16], obs[i][15:8], obs[i][7:0],
                   want[21:19], want[18], want[17], want[16], want[15:8], want[7:0]);
        end
      end
    end
  end

  initial begin
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    // start then 65 ticks -> 01:05
    cycle(0, 1, 0, 0, 0);
    ticks(65);
    // lap hold at 00:12 while counting continues
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0);
    ticks(12);
    cycle(0, 0, 1, 0, 0);
    ticks(3);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    // start with coincident tick at 00:07 still counts
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0);
    ticks(7);
    cycle(1, 1, 0, 0, 0);
    ticks(5);
    // clear beats start in PAUSE; clear ignored in RUN
    cycle(0, 1, 0, 1, 0);
    cycle(0, 1, 0, 0, 0);
    ticks(3);
    cycle(1, 0, 0, 1, 0);
    ticks(2);
    // terminal count: wrap / saturate at 59:59, saturate at 01:59
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0);
    ticks(3600);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0);
    ticks(2);
    // reset while in LAP at 03:21
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0);
    ticks(201);
    cycle(0, 0, 1, 0, 0);
    cycle(1, 1, 1, 1, 1);
    cycle(0, 1, 0, 0, 0);
    ticks(2);
    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      cycle(1'($urandom_range(0, 1)),
            1'($urandom_range(0, 11) == 0),
            1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 599) == 0));
    end
    cycle(0, 0, 0, 0, 0);
    repeat (6) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d responses left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
